// File: rtl/ht_cmd_arb_if.sv
// Command bus between the request sources, the arbiter and the hash-calc stage.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface ht_cmd_arb_if #(
  parameter int N       = 4,
  parameter int D_WIDTH = 64,
  parameter int SRC_W   = $clog2(N)
);
  logic [N*D_WIDTH-1:0] req_data_i;
  logic [N-1:0]         req_valid_i;
  logic [N-1:0]         req_ready_o;
  logic [D_WIDTH-1:0]   pdata_out_o;
  logic [SRC_W-1:0]     pdata_out_src_o;
  logic                 pdata_out_valid_o;
  logic                 pdata_out_ready_i;

  modport slave (
    input  req_data_i,
    input  req_valid_i,
    output req_ready_o,
    output pdata_out_o,
    output pdata_out_src_o,
    output pdata_out_valid_o,
    input  pdata_out_ready_i
  );

  modport master (
    output req_data_i,
    output req_valid_i,
    input  req_ready_o,
    input  pdata_out_o,
    input  pdata_out_src_o,
    input  pdata_out_valid_o,
    output pdata_out_ready_i
  );
endinterface

// File: rtl/ht_cmd_arb.sv
// N-way round-robin arbiter with bounded bursts in front of the hash-calc stage.
// One registered output stage; each command is tagged with its source index.
module ht_cmd_arb #(
  parameter int N         = 4,
  parameter int D_WIDTH   = 64,
  parameter int MAX_BURST = 2
) (
  input logic          clk_i,
  input logic          rst_n_i,
  ht_cmd_arb_if.slave  bus
);
  localparam int SRC_W = $clog2(N);
  // A burst may continue while fewer than MAX_BURST-1 extra grants were given.
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

  if (N < 2 || N > 16) begin : g_chk_n
    $error("ht_cmd_arb: N=%0d outside 2..16", N);
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_burst
    $error("ht_cmd_arb: MAX_BURST=%0d outside 1..255", MAX_BURST);
  end

  logic [D_WIDTH-1:0] req_word [N];
  logic [D_WIDTH-1:0] out_data;
  logic [SRC_W-1:0]   out_src;
  logic               out_valid;
  logic [SRC_W-1:0]   cur_src;
  // rr_ptr always holds (last granted source + 1) mod N; it is 0 after reset.
  logic [SRC_W-1:0]   rr_ptr;
  logic [7:0]         burst_cnt;
  logic               burst_active;

  logic               ld;
  logic               burst_go;
  logic               grant;
  logic [SRC_W-1:0]   sel;
  logic [SRC_W-1:0]   sel_inc;
  logic [SRC_W-1:0]   idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      assign req_word[gi] = bus.req_data_i[gi*D_WIDTH +: D_WIDTH];
      // Ready is suppressed while reset is held so no source sees a handshake.
      assign bus.req_ready_o[gi] = rst_n_i && ld && grant && (sel == SRC_W'(gi));
    end
  endgenerate

  assign ld       = !out_valid || bus.pdata_out_ready_i;
  assign burst_go = burst_active && bus.req_valid_i[cur_src] && (burst_cnt < BURST_LIM);
  assign sel_inc  = (sel == SRC_W'(N - 1)) ? '0 : sel + 1'b1;

  // Grant selection: keep the current burst going, else first valid source after the last grant.
  always_comb begin
    grant = 1'b0;
    sel   = '0;
    idx   = '0;
    if (burst_go) begin
      grant = 1'b1;
      sel   = cur_src;
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = SRC_W'((int'(rr_ptr) + i) % N);
        if (!grant && bus.req_valid_i[idx]) begin
          grant = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  // Output stage and arbitration state; everything holds while the output is stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_src      <= '0;
      cur_src      <= '0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      burst_active <= 1'b0;
    end else if (ld) begin
      if (grant) begin
        out_data     <= req_word[sel];
        out_src      <= sel;
        out_valid    <= 1'b1;
        rr_ptr       <= sel_inc;
        burst_active <= 1'b1;
        // A re-grant found by the circular search (sole requester) starts a fresh burst.
        if (burst_go) begin
          burst_cnt <= burst_cnt + 8'd1;
        end else begin
          cur_src   <= sel;
          burst_cnt <= '0;
        end
      end else begin
        out_valid    <= 1'b0;
        burst_active <= 1'b0;
      end
    end
  end

  assign bus.pdata_out_o       = out_data;
  assign bus.pdata_out_src_o   = out_src;
  assign bus.pdata_out_valid_o = out_valid;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0(bus.req_ready_o));

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (out_valid && !bus.pdata_out_ready_i) |=> ($stable(out_data) && $stable(out_src)));
endmodule

// File: doc/ht_cmd_arb.md
Name: ht_cmd_arb

Overview:
- N-way round-robin arbiter that shares the single hash-calculation / hash-table command pipeline between several command sources (e.g. host ports, aging engine).
- Selects one valid command per cycle and registers it into a one-entry output stage.
- Tags each command with its source index, so downstream responses can be routed back to the requester.
- Sits directly in front of the hash-calc stage and uses the same valid/ready handshake.

Parameters:
- N, 4, number of requesters (2..16).
- D_WIDTH, 64, width of one command word (packed pdata).
- MAX_BURST, 2, max consecutive grants to one source while others wait (1..255); 1 gives pure round-robin.
- SRC_W, $clog2(N), width of source tag (derived; do not override).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset; deassertion synchronous to clk_i externally.
- req_data_i  in  N*D_WIDTH  command words; source k occupies bits [k*D_WIDTH +: D_WIDTH].
- req_valid_i  in  N  per-source valid.
- req_ready_o  out  N  per-source ready; one-hot or zero.
- pdata_out_o  out  D_WIDTH  granted command, registered.
- pdata_out_src_o  out  SRC_W  index of the source that issued pdata_out_o.
- pdata_out_valid_o  out  1  output valid.
- pdata_out_ready_i  in  1  downstream ready.

Behaviour:
- Reset (rst_n_i low, async) clears all state:
  - pdata_out_valid_o=0, pdata_out_o=0, pdata_out_src_o=0;
  - rr pointer=0, cur_src=0, burst_cnt=0, burst_active=0;
  - req_ready_o=0 while in reset.
- Load enable: ld = !pdata_out_valid_o | pdata_out_ready_i. The output register advances only when ld=1. Throughput is 1 command/cycle. Latency is 1 cycle from accepted input to pdata_out_valid_o.
- Grant selection (combinational, evaluated every cycle):
  - Burst continue: if burst_active && req_valid_i[cur_src] && burst_cnt < MAX_BURST-1, grant cur_src.
  - Otherwise: grant the first k with req_valid_i[k]=1, searching circularly from (cur_src+1) mod N. After reset the search starts at index 0 (burst_active=0 means start at the rr pointer, which is 0).
  - Otherwise: no grant.
- req_ready_o[k] = ld && grant && (sel==k). req_ready_o may depend on req_valid_i; sources must not make valid depend on ready.
- Transfer on source k (req_valid_i[k] && req_ready_o[k]):
  - pdata_out_o <= req_data_i[k]; pdata_out_src_o <= k; pdata_out_valid_o <= 1.
  - If k == cur_src && burst_active: burst_cnt <= burst_cnt+1. Otherwise: cur_src <= k, burst_cnt <= 0.
  - burst_active <= 1.
- ld=1 and no grant: pdata_out_valid_o <= 0. Data and tag hold their old values (don't-care).
- Idle/burst interaction:
  - If cur_src drops valid, the burst ends immediately. burst_active is cleared on any ld cycle with no grant.
  - If cur_src is the only valid requester, it is re-granted even at burst_cnt = MAX_BURST-1. The circular search wraps back to it and burst_cnt resets to 0.
- Output stall: pdata_out_valid_o=1 && pdata_out_ready_i=0:
  - output register, tag and arbitration state hold;
  - all req_ready_o = 0.
- Wrap-around: the search index is computed mod N. For non-power-of-2 N, indices ≥ N are never granted.
- Reset mid-operation: the pending output is dropped, with no partial handshake. The arbiter restarts from index 0.
- Assertions (sim-only):
  - $onehot0(req_ready_o);
  - pdata_out_o and pdata_out_src_o stable while valid && !ready;
  - N and MAX_BURST range-checked with $error at elaboration.

Test Plan:
- Reset: hold rst_n_i low with all req_valid_i=1 -> pdata_out_valid_o=0, req_ready_o=4'b0000. On release, first grant is source 0, out_src=0 one cycle later.
- Pure round-robin (MAX_BURST=1, N=4): all four valid continuously, downstream ready=1 -> out_src sequence 0,1,2,3,0,1… with one command per cycle and no bubbles.
- Burst (MAX_BURST=2): all valid -> out_src sequence 0,0,1,1,2,2,3,3,0. Source 1 alone valid for 5 cycles -> 1,1,1,1,1 with no bubble.
- Backpressure: ready low for 3 cycles while output holds command 0xA5 from src 2 -> data and tag stable, req_ready_o=0. After ready rises, next source is 2 (burst) or 3, per the burst rule.
- Sparse requests: only sources 1 and 3 valid, MAX_BURST=1 -> sequence 1,3,1,3. Source 3 drops valid -> 1,1,1 with burst_cnt wrapping.
- Async reset mid-stall: assert rst_n_i low while valid=1 and ready=0 -> pdata_out_valid_o falls immediately (same cycle, before the next clock edge), and post-reset arbitration starts at source 0.
